// File: rtl/clock_pkg.sv
// Shared types and constants for the clock controller.
// Mode encoding, time-of-day constants and field-step helpers.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_t;

    localparam int SEC_PER_DAY  = 86400;
    localparam int SEC_PER_HOUR = 3600;
    localparam int SEC_PER_MIN  = 60;
    localparam int SEC_W        = 17;

    function automatic mode_t next_mode(input mode_t m);
        mode_t r;
        case (m)
            RUN:     r = SET_H;
            SET_H:   r = SET_M;
            SET_M:   r = SET_S;
            default: r = RUN;
        endcase
        return r;
    endfunction

    // Step the field selected by m; each field wraps on its own,
    // never carrying into the next larger field.
    function automatic logic [SEC_W-1:0] field_inc(
        input mode_t            m,
        input logic [SEC_W-1:0] t
    );
        int s;
        int hh;
        int mm;
        int ss;
        int r;
        s  = int'(t);
        hh = s / SEC_PER_HOUR;
        mm = (s / SEC_PER_MIN) % SEC_PER_MIN;
        ss = s % SEC_PER_MIN;
        case (m)
            SET_H: r = (hh == SEC_PER_DAY / SEC_PER_HOUR - 1)
                     ? s - (SEC_PER_DAY - SEC_PER_HOUR)
                     : s + SEC_PER_HOUR;
            SET_M: r = (mm == SEC_PER_MIN - 1)
                     ? s - (SEC_PER_HOUR - SEC_PER_MIN)
                     : s + SEC_PER_MIN;
            SET_S: r = (ss == SEC_PER_MIN - 1)
                     ? s - (SEC_PER_MIN - 1)
                     : s + 1;
            default: r = s;
        endcase
        return SEC_W'(r);
    endfunction

endpackage

// File: rtl/clock_ctrl_key_debounce.sv
// Key conditioner: 2-FF sync, debounce, one-cycle press on 1->0.
// Ports: clk, pow (async low reset), key (raw, active low), press.
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic pow,
    input  logic key,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          s1;
    logic          s2;
    logic          level;
    logic          arm;
    logic [1:0]    vld;
    logic [CW-1:0] cnt;

    // arm is only set once the synchronizer has carried a real released
    // sample, so a key held through reset release never yields a press.
    always_ff @(posedge clk or negedge pow) begin
        if (!pow) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            vld   <= 2'b00;
            arm   <= 1'b0;
            press <= 1'b0;
        end else begin
            s1    <= key;
            s2    <= s1;
            vld   <= {vld[0], 1'b1};
            press <= 1'b0;
            if (vld[1] && s2) begin
                arm <= 1'b1;
            end
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                cnt   <= '0;
                level <= s2;
                press <= arm & ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// Time-of-day clock with RUN/SET_H/SET_M/SET_S editing via two keys.
// Ports: clk, pow, key_mode, key_inc -> tick_1s, sec_of_day, mode, blink.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int INIT_SEC     = 85680
) (
    input  logic             clk,
    input  logic             pow,
    input  logic             key_mode,
    input  logic             key_inc,
    output logic             tick_1s,
    output logic [SEC_W-1:0] sec_of_day,
    output logic [1:0]       mode,
    output logic             blink
);

    localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int HALF = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    mode_t         mode_q;
    mode_t         mode_nxt;
    logic          run;
    logic          mode_ev;
    logic          inc_ev;
    logic [PW-1:0] pres;
    logic [PW-1:0] pres_inc;
    logic [BW-1:0] bcnt;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key_mode (
        .clk  (clk),
        .pow  (pow),
        .key  (key_mode),
        .press(mode_ev)
    );

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key_inc (
        .clk  (clk),
        .pow  (pow),
        .key  (key_inc),
        .press(inc_ev)
    );

    always_comb begin
        run      = (mode_q == RUN);
        mode_nxt = mode_ev ? next_mode(mode_q) : mode_q;
        pres_inc = (pres == PW'(CLK_HZ - 1)) ? '0 : pres + 1'b1;
    end

    assign mode = mode_q;

    // tick_1s is registered one edge early so it is high exactly while
    // the prescaler sits at its terminal count; leaving RUN kills it.
    always_ff @(posedge clk or negedge pow) begin
        if (!pow) begin
            mode_q     <= RUN;
            sec_of_day <= SEC_W'(INIT_SEC);
            tick_1s    <= 1'b0;
            blink      <= 1'b0;
            pres       <= '0;
            bcnt       <= '0;
        end else begin
            mode_q <= mode_nxt;

            if (run && !mode_ev) begin
                pres    <= pres_inc;
                tick_1s <= (pres_inc == PW'(CLK_HZ - 1));
            end else begin
                pres    <= '0;
                tick_1s <= 1'b0;
            end

            // An increment coinciding with a mode change is dropped.
            if (tick_1s) begin
                sec_of_day <= (sec_of_day == SEC_W'(SEC_PER_DAY - 1))
                            ? '0 : sec_of_day + 1'b1;
            end else if (inc_ev && !mode_ev && !run) begin
                sec_of_day <= field_inc(mode_q, sec_of_day);
            end

            if (run || mode_nxt == RUN) begin
                bcnt  <= '0;
                blink <= 1'b0;
            end else if (bcnt == BW'(HALF - 1)) begin
                bcnt  <= '0;
                blink <= ~blink;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with a cycle-stamped scoreboard.
// Ports driven: clk, pow, key_mode, key_inc; all outputs observed.
module tb_clock_ctrl;

    localparam int CLK_HZ = 8;
    localparam int DEB    = 4;
    localparam int INIT   = 86398;

    logic        clk      = 1'b0;
    logic        pow      = 1'b0;
    logic        key_mode = 1'b1;
    logic        key_inc  = 1'b1;
    logic        tick_1s;
    logic [16:0] sec_of_day;
    logic [1:0]  mode;
    logic        blink;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int n_push  = 0;

    typedef struct {
        int due;
        int id;
        int m;
        int s;
        int t;
        int b;
    } exp_t;

    exp_t sb[$];

    clock_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_CYC(DEB),
        .INIT_SEC    (INIT)
    ) dut (
        .clk       (clk),
        .pow       (pow),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .tick_1s   (tick_1s),
        .sec_of_day(sec_of_day),
        .mode      (mode),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // -1 in any field means that output is not checked for this entry.
    task automatic push(input int due, input int m, input int s,
                        input int t, input int b);
        exp_t e;
        e.due = due;
        e.id  = n_push;
        e.m   = m;
        e.s   = s;
        e.t   = t;
        e.b   = b;
        n_push++;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : sb_chk
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.m >= 0)
                check($sformatf("sb%0d.mode@%0d", e.id, cyc),
                      32'(mode), e.m);
            if (e.s >= 0)
                check($sformatf("sb%0d.sec@%0d", e.id, cyc),
                      32'(sec_of_day), e.s);
            if (e.t >= 0)
                check($sformatf("sb%0d.tick@%0d", e.id, cyc),
                      32'(tick_1s), e.t);
            if (e.b >= 0)
                check($sformatf("sb%0d.blink@%0d", e.id, cyc),
                      32'(blink), e.b);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        key_mode = 1'b0;
        step(7);
        key_mode = 1'b1;
        step(6);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            key_inc = 1'b0;
            step(7);
            key_inc = 1'b1;
            step(6);
        end
    endtask

    initial begin
        int c0;
        int c;
        int frozen;
        int ticks;

        step(3);
        check("rst.sec", 32'(sec_of_day), INIT);
        check("rst.mode", 32'(mode), 0);
        check("rst.tick", 32'(tick_1s), 0);
        check("rst.blink", 32'(blink), 0);

        // First two seconds after power-up, crossing midnight.
        pow = 1'b1;
        c0  = cyc;
        for (int n = 1; n <= 18; n++)
            push(c0 + n, 0, (INIT + n / 8) % 86400,
                 (n % 8 == 7) ? 1 : 0, 0);
        step(18);

        // Short glitch on key_mode is ignored.
        c = cyc;
        key_mode = 1'b0;
        step(3);
        key_mode = 1'b1;
        push(c + 12, 0, -1, -1, 0);
        step(10);

        // Clean press: mode changes 7 cycles after the falling edge.
        c      = cyc;
        frozen = (INIT + (c + 7 - c0) / 8) % 86400;
        key_mode = 1'b0;
        push(c + 6, 0, -1, -1, -1);
        push(c + 7, 1, frozen, 0, 0);
        push(c + 8, 1, frozen, 0, 0);
        push(c + 9, 1, -1, -1, 1);
        push(c + 10, 1, -1, -1, 1);
        push(c + 11, -1, -1, -1, 0);
        step(10);
        key_mode = 1'b1;
        push(c + 30, 1, frozen, 0, -1);
        step(25);

        // SET_H from 00:00:02 up to 23:00:02.
        press_inc(1);
        check("seth.first", 32'(sec_of_day), 3602);
        press_inc(22);
        check("seth.h23", 32'(sec_of_day), 82802);
        press_mode();
        check("setm.mode", 32'(mode), 2);
        press_inc(1);
        check("setm.first", 32'(sec_of_day), 82862);
        press_inc(57);
        check("setm.m58", 32'(sec_of_day), 86282);
        press_mode();
        check("sets.mode", 32'(mode), 3);
        press_inc(57);
        check("sets.s59", 32'(sec_of_day), 86339);

        // Brief RUN pass: prescaler restarts, one tick, blink cleared.
        key_mode = 1'b0;
        step(7);
        check("run.mode", 32'(mode), 0);
        check("run.blink", 32'(blink), 0);
        check("run.sec", 32'(sec_of_day), 86339);
        key_mode = 1'b1;
        step(6);
        press_mode();
        check("seth2.mode", 32'(mode), 1);
        check("seth2.sec", 32'(sec_of_day), 86340);

        // Hour wrap 23:59:00 -> 00:59:00.
        press_inc(1);
        check("seth.wrap", 32'(sec_of_day), 3540);
        press_inc(23);
        check("seth.back", 32'(sec_of_day), 86340);
        press_mode();
        check("setm2.mode", 32'(mode), 2);

        // Coincident key_mode and key_inc: mode wins, no increment.
        key_mode = 1'b0;
        key_inc  = 1'b0;
        step(7);
        check("both.mode", 32'(mode), 3);
        check("both.sec", 32'(sec_of_day), 86340);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        step(6);
        check("both.sec2", 32'(sec_of_day), 86340);

        // Second wrap 23:59:59 -> 23:59:00, then idle in SET_S.
        press_inc(59);
        check("sets.86399", 32'(sec_of_day), 86399);
        press_inc(1);
        check("sets.wrap", 32'(sec_of_day), 86340);
        ticks = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (tick_1s) ticks++;
        end
        check("idle.ticks", 32'(ticks), 0);
        check("idle.sec", 32'(sec_of_day), 86340);

        // Reset mid SET_M, between clock edges.
        press_mode();
        press_mode();
        press_mode();
        check("pre.mode", 32'(mode), 2);
        step(3);
        @(posedge clk);
        #3 pow = 1'b0;
        #1;
        check("arst.mode", 32'(mode), 0);
        check("arst.sec", 32'(sec_of_day), INIT);
        check("arst.blink", 32'(blink), 0);
        check("arst.tick", 32'(tick_1s), 0);

        // Key held through reset release yields no event.
        key_mode = 1'b0;
        step(2);
        pow = 1'b1;
        step(20);
        check("held.mode", 32'(mode), 0);
        key_mode = 1'b1;
        step(8);
        press_mode();
        check("after.mode", 32'(mode), 1);

        for (int i = 0; i < 100 && sb.size() > 0; i++) step(1);
        check("sb.drain", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
